// File: rtl/clk_div_pkg.sv
// +--------------------------------------------------------------------+
// | clk_div_pkg : shared types and defaults for the divide-by-6 taps    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package clk_div_pkg;

  localparam int DIV6_PERIOD = 6;
  localparam int MON_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

endpackage

`default_nettype wire

// File: rtl/clk_edge_detect.sv
// +--------------------------------------------------------------------+
// | clk_edge_detect : registers a divider tap, flags rising/falling    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module clk_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_clk_in,
  output logic o_rise,
  output logic o_fall
);

  logic r_clk_in_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_in_d <= 1'b0;
    end else begin
      r_clk_in_d <= i_clk_in;
    end
  end

  assign o_rise = i_clk_in & ~r_clk_in_d;
  assign o_fall = ~i_clk_in & r_clk_in_d;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// +--------------------------------------------------------------------+
// | clk_div_monitor : measures divider period/high time, tracks lock   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = MON_CNT_W,
  parameter int EXP_PERIOD = DIV6_PERIOD,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  localparam int              c_LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_MAX = c_LOCK_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  mon_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [c_LOCK_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0]    r_period;
  logic [CNT_W-1:0]    r_high_time;
  logic                r_period_valid;
  logic                r_locked;
  logic                r_err;

  logic                w_rise;
  logic                w_fall;
  logic [CNT_W:0]      w_cnt_ext;
  logic [CNT_W:0]      w_exp;
  logic [CNT_W:0]      w_abs_dev;
  logic                w_in_tol;
  logic [c_LOCK_W-1:0] w_lock_inc;

  clk_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .i_clk_in (clk_in),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // One extra bit keeps the deviation from wrapping for any count value
  assign w_cnt_ext  = {1'b0, r_cnt};
  assign w_exp      = (CNT_W+1)'(EXP_PERIOD);
  assign w_abs_dev  = (w_cnt_ext >= w_exp) ? (w_cnt_ext - w_exp) : (w_exp - w_cnt_ext);
  assign w_in_tol   = (w_abs_dev <= (CNT_W+1)'(TOL));
  assign w_lock_inc = (r_lock_cnt == c_LOCK_MAX) ? r_lock_cnt : r_lock_cnt + c_LOCK_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_lock_cnt     <= '0;
      r_period       <= '0;
      r_high_time    <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      // Clear first; any error set further down overrides it on the same edge
      if (err_clr) begin
        r_err <= 1'b0;
      end
      if (!enable) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_cnt   <= c_CNT_ONE;
              r_state <= MEASURE;
            end
          end
          MEASURE: begin
            if (w_fall) begin
              r_high_time <= r_cnt;
            end
            if (w_rise) begin
              r_period       <= r_cnt;
              r_period_valid <= 1'b1;
              r_cnt          <= c_CNT_ONE;
              if (w_in_tol) begin
                r_lock_cnt <= w_lock_inc;
                r_locked   <= (w_lock_inc == c_LOCK_MAX);
              end else begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
                if (r_locked) begin
                  r_err <= 1'b1;
                end
              end
            end else if (r_cnt == c_CNT_MAX) begin
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_lock_cnt <= '0;
              r_cnt      <= '0;
              r_state    <= ARM;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign period       = r_period;
  assign high_time    = r_high_time;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign err          = r_err;

endmodule

`default_nettype wire

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Downstream checker for the divide-by-6 clock divider. It samples the divider output as data in the source `clk` domain and measures each period and high time in `clk` cycles. It declares lock after consecutive in-tolerance periods and raises a sticky error on a ratio violation or a stuck divider output. It sits beside the divider and feeds status to test logic and software.

Parameters:
CNT_W, 8, width of the period counter and of the period/high_time outputs
EXP_PERIOD, 6, expected period in clk cycles
TOL, 0, allowed absolute deviation from EXP_PERIOD, in cycles
LOCK_CNT, 4, consecutive in-tolerance periods required to assert locked (must be ≥ 1)

Ports:
clk  input  1  system clock; the same clock that drives the divider
reset  input  1  asynchronous, active-low reset
clk_in  input  1  divider output; registered on clk upstream, so no synchronizer is needed
enable  input  1  monitor enable; level-sensitive
err_clr  input  1  one-cycle pulse that clears err
period  output  CNT_W  last measured period in clk cycles
high_time  output  CNT_W  clk cycles from the last rise to the following fall
period_valid  output  1  one-cycle pulse; period is updated on the same edge
locked  output  1  ratio is within tolerance and stable
err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0; internal state is cleared:
  - state=IDLE, cnt=0, lock_cnt=0, clk_in_d=0.
- Edge detection, registered each clk edge:
  - clk_in_d <= clk_in
  - rise = clk_in & ~clk_in_d
  - fall = ~clk_in & clk_in_d
- States:
  - IDLE: entered whenever enable=0, from any state. On entry, cnt and lock_cnt are cleared and locked=0. period, high_time and err hold their values. Goes to ARM when enable=1.
  - ARM: waits for rise. On rise: cnt<=1, go to MEASURE. The first rise only arms; it produces no measurement.
  - MEASURE: on each edge without rise, cnt<=cnt+1.
    - On fall: high_time<=cnt.
    - On rise: period<=cnt, period_valid=1 on that same edge, cnt<=1.
- Timing example: with a divide-by-6 input, a rise at edge t gives cnt values 2..6 on edges t+1..t+5. The next rise at t+6 captures period=6. The fall at t+3 captures high_time=3.
- Tolerance check on each captured period: in_tol = |period − EXP_PERIOD| ≤ TOL, computed on CNT_W+1 bits so it cannot wrap.
  - in_tol=1: lock_cnt increments, saturating at LOCK_CNT. locked=1 on the edge where lock_cnt reaches LOCK_CNT.
  - in_tol=0: lock_cnt<=0 and locked<=0 on the same edge as period_valid. If locked was 1, err<=1. Before lock, mismatches only reset lock_cnt.
- Timeout: in MEASURE, if cnt = 2^CNT_W−1 and no rise occurs, then:
  - err<=1, locked<=0, lock_cnt<=0, cnt<=0
  - go to ARM
  - no period_valid pulse is generated.
- err_clr: clears err on the next edge. If a set condition occurs on the same edge, the set wins.
- Simultaneous rise and fall are impossible on one edge by construction. A fall in ARM is ignored.
- When enable falls mid-period, the partial measurement is discarded and no pulse is generated.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum {IDLE, ARM, MEASURE}
  - default constants DIV6_PERIOD=6 and MON_CNT_W=8, shared with the divider bench.
- One sub-module: clk_edge_detect. It registers clk_in and outputs rise and fall; it is reusable for other divider taps.

Test Plan:
1. Reset released with the divider running divide-by-6 and enable=1 → period_valid every 6 cycles; first pulse 6 cycles after the arming rise; period=6, high_time=3; locked=1 on the 4th pulse; err=0.
2. After lock, the input period is changed to 8 (4 high, 4 low) → next pulse has period=8 and high_time=4; locked=0 and err=1 on that same edge.
3. clk_in held at 0 with CNT_W=8 after arming → err=1 once cnt hits 255; state returns to ARM; no period_valid pulse.
4. err=1, then err_clr asserted on the same edge as a timeout → err stays 1. err_clr alone on a later edge → err=0.
5. reset driven low mid-MEASURE between clock edges → all outputs are 0 immediately, without waiting for a clk edge. After release, the first rise only arms.
6. enable dropped for 3 cycles mid-period, then raised → no pulse from the partial period; locked=0; first new pulse comes 6 cycles after the first rise following re-enable; locked again after 4 pulses.
